// File: rtl/qsum_if.sv
// Valid/ready data transfer channel; the producer drives valid/data and the consumer drives ready.
interface dti #(
   parameter int W = 8
);
   logic         valid;
   logic         ready;
   logic [W-1:0] data;

   modport producer (output valid, output data, input ready);
   modport consumer (input valid, input data, output ready);
endinterface

// File: rtl/qsum.sv
// Queue reducer: sums and counts each innermost transaction and emits one {eot, cnt, sum} record one cycle after its last item.
// Non-last items are always taken; a last item waits while an undrained record sits in the output register.
module qsum #(
   parameter int W_DIN = 16,
   parameter int LVL   = 1,
   parameter int W_SUM = 24,
   parameter int W_CNT = 16
) (
   input logic  clk,
   input logic  rst,
   dti.consumer din,
   dti.producer dout
);
   typedef struct packed {
      logic [LVL-1:0]   eot;
      logic [W_CNT-1:0] cnt;
      logic [W_SUM-1:0] sum;
   } rec_t;

   logic [W_SUM-1:0] acc_sum;
   logic [W_CNT-1:0] acc_cnt;
   logic [W_SUM-1:0] sum_nxt;
   logic [W_CNT-1:0] cnt_nxt;
   rec_t             out_reg;
   logic             out_valid;

   logic [LVL-1:0]   in_eot;
   logic [W_DIN-1:0] in_dat;
   logic             din_eot;
   logic             din_hs;
   logic             dout_hs;

   assign in_eot  = din.data[LVL+W_DIN-1:W_DIN];
   assign in_dat  = din.data[W_DIN-1:0];
   assign din_eot = in_eot[0];

   // Last item may only enter when the output slot is free or draining this cycle.
   assign din.ready = !din_eot || !out_valid || dout.ready;
   assign din_hs    = din.valid && din.ready;
   assign dout_hs   = out_valid && dout.ready;

   assign dout.valid = out_valid;
   assign dout.data  = out_reg;

   assign sum_nxt = acc_sum + W_SUM'(in_dat);
   assign cnt_nxt = (acc_cnt == {W_CNT{1'b1}}) ? acc_cnt : acc_cnt + W_CNT'(1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_sum   <= '0;
         acc_cnt   <= '0;
         out_reg   <= '0;
         out_valid <= 1'b0;
      end else begin
         if (din_hs && din_eot) begin
            out_reg.eot <= in_eot;
            out_reg.cnt <= cnt_nxt;
            out_reg.sum <= sum_nxt;
            acc_sum     <= '0;
            acc_cnt     <= '0;
         end else if (din_hs) begin
            acc_sum <= sum_nxt;
            acc_cnt <= cnt_nxt;
         end

         if (din_hs && din_eot)
            out_valid <= 1'b1;
         else if (dout_hs)
            out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_qsum.sv
// Directed bench for qsum: default build driven from a cycle table, narrow LVL=2 build and reset by hand.
module tb_qsum;
   logic clk;
   logic rst;

   dti #(.W(17)) a_in ();
   dti #(.W(41)) a_out ();
   dti #(.W(18)) b_in ();
   dti #(.W(20)) b_out ();

   qsum dut_a (
      .clk  (clk),
      .rst  (rst),
      .din  (a_in),
      .dout (a_out)
   );

   qsum #(.W_DIN(16), .LVL(2), .W_SUM(16), .W_CNT(2)) dut_b (
      .clk  (clk),
      .rst  (rst),
      .din  (b_in),
      .dout (b_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        vld;
      logic        eot;
      logic [15:0] dat;
      logic        ordy;
      logic        e_rdy;
      logic        e_ovld;
      logic [15:0] e_cnt;
      logic [23:0] e_sum;
   } vec_t;

   vec_t tbl [15];

   function automatic vec_t mk(input logic vld, input logic eot, input logic [15:0] dat,
                               input logic ordy, input logic e_rdy, input logic e_ovld,
                               input logic [15:0] e_cnt, input logic [23:0] e_sum);
      vec_t v;
      v.vld = vld; v.eot = eot; v.dat = dat; v.ordy = ordy;
      v.e_rdy = e_rdy; v.e_ovld = e_ovld; v.e_cnt = e_cnt; v.e_sum = e_sum;
      return v;
   endfunction

   task automatic b_item(input logic [1:0] eot, input logic [15:0] dat);
      @(negedge clk);
      b_in.valid = 1'b1;
      b_in.data  = {eot, dat};
   endtask

   initial begin
      // Expectations describe the state seen after the inputs of that row are applied, before its clock edge.
      tbl[0]  = mk(1, 0, 16'd3,    1, 1, 0, 0, 0);
      tbl[1]  = mk(1, 0, 16'd5,    1, 1, 0, 0, 0);
      tbl[2]  = mk(1, 1, 16'd7,    1, 1, 0, 0, 0);
      tbl[3]  = mk(0, 0, 16'd0,    1, 1, 1, 3, 15);
      tbl[4]  = mk(1, 1, 16'h0010, 1, 1, 0, 0, 0);
      tbl[5]  = mk(1, 1, 16'h0020, 1, 1, 1, 1, 24'h10);
      tbl[6]  = mk(0, 0, 16'd0,    1, 1, 1, 1, 24'h20);
      tbl[7]  = mk(1, 1, 16'h0055, 0, 1, 0, 0, 0);
      tbl[8]  = mk(1, 0, 16'd1,    0, 1, 1, 1, 24'h55);
      tbl[9]  = mk(1, 0, 16'd2,    0, 1, 1, 1, 24'h55);
      tbl[10] = mk(1, 1, 16'd4,    0, 0, 1, 1, 24'h55);
      tbl[11] = mk(1, 1, 16'd4,    0, 0, 1, 1, 24'h55);
      tbl[12] = mk(1, 1, 16'd4,    1, 1, 1, 1, 24'h55);
      tbl[13] = mk(0, 0, 16'd0,    1, 1, 1, 3, 24'd7);
      tbl[14] = mk(0, 0, 16'd0,    1, 1, 0, 0, 0);

      rst = 1'b0;
      a_in.valid = 1'b0; a_in.data = '0; a_out.ready = 1'b0;
      b_in.valid = 1'b0; b_in.data = '0; b_out.ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_a_out_valid", 64'(a_out.valid), 64'd0);
      chk("reset_a_out_data",  64'(a_out.data),  64'd0);
      chk("reset_b_out_valid", 64'(b_out.valid), 64'd0);
      chk("reset_a_in_ready",  64'(a_in.ready),  64'd1);
      rst = 1'b1;

      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         a_in.valid  = tbl[i].vld;
         a_in.data   = {tbl[i].eot, tbl[i].dat};
         a_out.ready = tbl[i].ordy;
         #1;
         chk($sformatf("row%0d_in_ready", i), 64'(a_in.ready), 64'(tbl[i].e_rdy));
         chk($sformatf("row%0d_out_valid", i), 64'(a_out.valid), 64'(tbl[i].e_ovld));
         if (tbl[i].e_ovld) begin
            chk($sformatf("row%0d_eot", i), 64'(a_out.data[40]), 64'd1);
            chk($sformatf("row%0d_cnt", i), 64'(a_out.data[39:24]), 64'(tbl[i].e_cnt));
            chk($sformatf("row%0d_sum", i), 64'(a_out.data[23:0]), 64'(tbl[i].e_sum));
         end
      end

      // Narrow build: 16-bit sum wraps, 2-bit count saturates, both eot bits forwarded.
      b_item(2'b00, 16'hFFFF);
      b_item(2'b01, 16'h0002);
      @(negedge clk);
      b_in.valid = 1'b0;
      #1;
      chk("wrap_valid", 64'(b_out.valid), 64'd1);
      chk("wrap_eot",   64'(b_out.data[19:18]), 64'h1);
      chk("wrap_cnt",   64'(b_out.data[17:16]), 64'd2);
      chk("wrap_sum",   64'(b_out.data[15:0]),  64'h0001);
      for (int k = 0; k < 4; k++) b_item(2'b10, 16'd1);
      b_item(2'b11, 16'd1);
      @(negedge clk);
      b_in.valid = 1'b0;
      #1;
      chk("sat_valid", 64'(b_out.valid), 64'd1);
      chk("sat_eot",   64'(b_out.data[19:18]), 64'h3);
      chk("sat_cnt",   64'(b_out.data[17:16]), 64'd3);
      chk("sat_sum",   64'(b_out.data[15:0]),  64'd5);

      // Asynchronous reset mid-transaction with a record pending.
      @(negedge clk);
      a_in.valid = 1'b1; a_in.data = {1'b1, 16'h0077}; a_out.ready = 1'b0;
      @(negedge clk);
      a_in.data = {1'b0, 16'd100};
      @(negedge clk);
      a_in.data = {1'b0, 16'd200};
      @(negedge clk);
      a_in.valid = 1'b0;
      #1;
      chk("pre_rst_valid", 64'(a_out.valid), 64'd1);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_valid", 64'(a_out.valid), 64'd0);
      chk("async_rst_data",  64'(a_out.data),  64'd0);
      @(negedge clk);
      rst = 1'b1; a_out.ready = 1'b1;
      @(negedge clk);
      a_in.valid = 1'b1; a_in.data = {1'b1, 16'd9};
      @(negedge clk);
      a_in.valid = 1'b0;
      #1;
      chk("post_rst_valid", 64'(a_out.valid), 64'd1);
      chk("post_rst_cnt",   64'(a_out.data[39:24]), 64'd1);
      chk("post_rst_sum",   64'(a_out.data[23:0]),  64'd9);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/qsum.md
# qsum

Queue reducer placed directly downstream of the queue filter stage. It consumes a queue of unsigned data items (format `{eot[LVL-1:0], data[W_DIN-1:0]}`, identical to the filter's output) and accumulates each innermost transaction, which is delimited by `eot[0]`. For every transaction it emits one record holding the item count, the wrapped sum, and the `eot` bits of the last item, so outer queue levels are preserved for later stages.

## Interface
- `W_DIN`, 16, width of the data field of each input item.
- `LVL`, 1, number of `eot` bits per item (queue depth); at least 1.
- `W_SUM`, 24, width of the sum field; at least `W_DIN`.
- `W_CNT`, 16, width of the count field.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `din`  dti.consumer  `LVL+W_DIN`  input queue items as `{eot, data}`; `valid`/`ready` handshake.
- `dout`  dti.producer  `LVL+W_CNT+W_SUM`  result record `{eot[LVL-1:0], cnt[W_CNT-1:0], sum[W_SUM-1:0]}`; `valid`/`ready` handshake.

## Operation
- State:
  - accumulator `acc_sum` (`W_SUM` bits) and `acc_cnt` (`W_CNT` bits);
  - a one-entry output register `out_reg` with flag `out_valid`.
- `dout.valid = out_valid`. `dout.data = out_reg`.
- Input handshake: `din_hs = din.valid && din.ready`.
- `din.ready = !din_eot || !out_valid || dout.ready`, where `din_eot = din.data.eot[0]`.
  - Non-last items are always accepted.
  - The last item of a transaction is accepted only if the output register is free, or is drained in the same cycle.
- On `din_hs` with `din_eot = 0`:
  - `acc_sum <= acc_sum + zext(data)`, modulo 2^`W_SUM`;
  - `acc_cnt <= sat(acc_cnt + 1)`.
- On `din_hs` with `din_eot = 1`:
  - `out_reg <= {din.eot, sat(acc_cnt+1), acc_sum + zext(data)}`;
  - `out_valid <= 1`;
  - `acc_sum <= 0`, `acc_cnt <= 0`.
- On a `dout` handshake with no simultaneous eot load: `out_valid <= 0`. `out_reg` data holds its value; it is don't-care while not valid.
- Simultaneous `dout` handshake and eot load: `out_reg` takes the new record and `out_valid` stays 1. No bubble is inserted.
- Arithmetic rules:
  - `sum` wraps silently.
  - `cnt` saturates at 2^`W_CNT`-1; it never wraps.
  - Data is treated as unsigned and zero-extended.
- A single-item transaction (first item carries `eot[0] = 1`) yields `cnt = 1`, `sum = data`.
- Upper `eot` bits of non-last items are ignored. Only the last item's `eot` vector is forwarded.
- `dout.data` is held stable while `dout.valid && !dout.ready`. `dout.valid` never drops without a handshake.

## Timing
- Reset (`rst = 0`, asynchronous) forces `out_valid = 0`, `dout.valid = 0`, `out_reg = 0`, `acc_sum = 0`, `acc_cnt = 0`.
  - Any partially accumulated transaction is discarded.
  - `din.ready` is combinational and may be 1 during reset; inputs presented during reset are not accumulated.
- Latency: the record is valid on `dout` one cycle after the handshake of the transaction's last item.
- Throughput: one input item per cycle. Back-to-back single-item transactions sustain one record per cycle while `dout.ready = 1`.
- Backpressure:
  - With `out_valid = 1` and `dout.ready = 0`, non-last items of the next transaction keep accumulating.
  - The next last item stalls (`din.ready = 0`) until `dout.ready = 1`.
- Combinational paths:
  - `dout.ready` to `din.ready` exists.
  - There is no `din.valid` to `dout.valid` path.

## Test plan
- LVL=1, items 3, 5, 7 (last with eot=1), `dout.ready` held 1 -> one record `cnt=3`, `sum=15`, `eot=1`, valid one cycle after the third handshake.
- Single-item transactions 0x0010, then 0x0020, back-to-back with `dout.ready` held 1 -> records (1, 0x10) and (1, 0x20) on consecutive cycles; `din.ready` stays 1 throughout.
- `dout.ready = 0` with one record pending; feed 1, 2, then a last item 4 -> 1 and 2 accepted; the last item stalls with `din.ready = 0`; `dout.data` stays stable. Raise `dout.ready` -> first record drains and the second record (3, 7) loads in the same cycle.
- W_SUM=16, items 0xFFFF and 0x0002 (last) -> `sum=0x0001`, `cnt=2`. With W_CNT=2 and five items of 1 -> `cnt=3` (saturated), `sum=5`.
- LVL=2, transactions with last eot `01` then `11` -> forwarded `eot` fields are `01` and `11` respectively.
- Assert `rst=0` asynchronously after two non-last items, then release and send 9 (last) -> `dout.valid` drops immediately during reset; the next record is `cnt=1`, `sum=9`.
